// File: rtl/uart_tx_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched_pkg
//  Description : Shared constants for the UART frame scheduler: frame field
//                widths, default sync byte and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_sched_pkg;

    // Frame fields
    localparam logic [7:0]  c_sync_byte = 8'hA5;
    localparam int unsigned c_byte_w    = 8;
    localparam int unsigned c_id_w      = 3;     // enough for up to 8 clients

    // FSM state encoding (also used as the WAIT return code)
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_sync    = 3'd1;
    localparam logic [2:0] c_st_id      = 3'd2;
    localparam logic [2:0] c_st_payload = 3'd3;
    localparam logic [2:0] c_st_csum    = 3'd4;
    localparam logic [2:0] c_st_wait    = 3'd5;

    // Client index as it appears on the wire in the ID field
    function automatic logic [7:0] id_byte(input logic [c_id_w-1:0] idx);
        return {5'b0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Picks the first requester after the
//                last winner (wrapping) and holds the rotation pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                advance,
    output logic [NUM_REQ-1:0]  winner_oh,
    output logic [c_id_w-1:0]   winner_idx,
    output logic                any_req
);

    logic [c_id_w-1:0] r_ptr;
    logic [7:0]        w_req8;
    logic [c_id_w-1:0] w_pos;
    logic              w_found;

    // Zero-extended request vector so any 3-bit index is in range
    assign w_req8  = 8'(req);
    assign any_req = |req;

    // Search starting one past the pointer, wrapping back to the pointer itself
    always_comb begin
        winner_idx = '0;
        w_found    = 1'b0;
        w_pos      = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_pos = c_id_w'((int'(r_ptr) + k) % int'(NUM_REQ));
            if (!w_found && w_req8[w_pos]) begin
                w_found    = 1'b1;
                winner_idx = w_pos;
            end
        end
    end

    // One-hot form of the winning index, empty when nobody requests
    always_comb begin
        winner_oh = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            winner_oh[i] = any_req && (winner_idx == c_id_w'(i));
        end
    end

    // Pointer moves to the winner whenever a grant is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= c_id_w'(NUM_REQ - 1);
        end else if (advance && any_req) begin
            r_ptr <= winner_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Shares one UART transmitter among NUM_REQ byte-stream
//                clients. Each burst goes out as SYNC, ID, payload, XOR csum.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  SYNC_BYTE      = c_sync_byte
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*8-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int unsigned c_len_w = $clog2(MAX_LEN + 1);
    localparam int unsigned c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_len_w-1:0] c_len_max = c_len_w'(MAX_LEN);
    localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT_CYCLES);

    logic [2:0]          r_state;
    logic [2:0]          r_ret;
    logic [NUM_REQ-1:0]  r_grant;
    logic [c_id_w-1:0]   r_idx;
    logic                r_busy;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_csum;
    logic [c_len_w-1:0]  r_len;
    logic [c_tmo_w-1:0]  r_tmo;
    logic                r_abort;

    logic [NUM_REQ-1:0]  w_win_oh;
    logic [c_id_w-1:0]   w_win_idx;
    logic                w_any;
    logic                w_arb_take;

    logic [7:0]          w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_accept;
    logic [c_len_w-1:0]  w_len_inc;
    logic [c_tmo_w-1:0]  w_tmo_inc;
    logic [7:0]          w_csum_out;

    logic                w_issue;
    logic [7:0]          w_issue_byte;
    logic [2:0]          w_issue_ret;
    logic                w_issue_id;

    assign w_arb_take = (r_state == c_st_idle);

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .advance    (w_arb_take),
        .winner_oh  (w_win_oh),
        .winner_idx (w_win_idx),
        .any_req    (w_any)
    );

    // Route the granted client's byte stream; other clients are invisible
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_grant[i]) begin
                w_sel_data  = w_sel_data | req_data[i*8 +: 8];
                w_sel_valid = w_sel_valid | req_valid[i];
                w_sel_last  = w_sel_last | req_last[i];
            end
        end
    end

    assign req_ready  = (r_state == c_st_payload) ? r_grant : '0;
    assign w_accept   = (r_state == c_st_payload) && w_sel_valid;
    assign w_len_inc  = r_len + 1'b1;
    assign w_tmo_inc  = (r_tmo == c_tmo_lim) ? r_tmo : r_tmo + 1'b1;
    assign w_csum_out = r_abort ? ~r_csum : r_csum;

    // Decide when a header/trailer byte goes out; WAIT looks ahead on tx_done
    // so the following byte starts the very next cycle
    always_comb begin
        w_issue      = 1'b0;
        w_issue_byte = '0;
        w_issue_ret  = c_st_idle;
        w_issue_id   = 1'b0;
        case (r_state)
            c_st_sync: begin
                w_issue      = 1'b1;
                w_issue_byte = SYNC_BYTE;
                w_issue_ret  = c_st_id;
            end
            c_st_id: begin
                w_issue      = 1'b1;
                w_issue_byte = id_byte(r_idx);
                w_issue_ret  = c_st_payload;
                w_issue_id   = 1'b1;
            end
            c_st_csum: begin
                w_issue      = 1'b1;
                w_issue_byte = w_csum_out;
                w_issue_ret  = c_st_idle;
            end
            c_st_wait: begin
                if (tx_done && (r_ret == c_st_id)) begin
                    w_issue      = 1'b1;
                    w_issue_byte = id_byte(r_idx);
                    w_issue_ret  = c_st_payload;
                    w_issue_id   = 1'b1;
                end else if (tx_done && (r_ret == c_st_csum)) begin
                    w_issue      = 1'b1;
                    w_issue_byte = w_csum_out;
                    w_issue_ret  = c_st_idle;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer: arbitration, byte issue, payload intake, completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_ret      <= c_st_idle;
            r_grant    <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_csum     <= '0;
            r_len      <= '0;
            r_tmo      <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            if (w_issue) begin
                r_tx_data  <= w_issue_byte;
                r_tx_start <= 1'b1;
                r_ret      <= w_issue_ret;
                r_state    <= c_st_wait;
                if (w_issue_id) begin
                    r_csum <= id_byte(r_idx);
                end
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_any) begin
                            r_grant <= w_win_oh;
                            r_idx   <= w_win_idx;
                            r_busy  <= 1'b1;
                            r_csum  <= '0;
                            r_len   <= '0;
                            r_tmo   <= '0;
                            r_abort <= 1'b0;
                            r_state <= c_st_sync;
                        end
                    end
                    c_st_payload: begin
                        if (w_accept) begin
                            r_tx_data  <= w_sel_data;
                            r_tx_start <= 1'b1;
                            r_csum     <= r_csum ^ w_sel_data;
                            r_len      <= w_len_inc;
                            r_tmo      <= '0;
                            r_state    <= c_st_wait;
                            if (w_sel_last || (w_len_inc == c_len_max)) begin
                                // Hitting the length cap without last is a truncation
                                r_ret   <= c_st_csum;
                                r_abort <= !w_sel_last;
                            end else begin
                                r_ret   <= c_st_payload;
                            end
                        end else begin
                            r_tmo <= w_tmo_inc;
                            if (w_tmo_inc == c_tmo_lim) begin
                                r_abort <= 1'b1;
                                r_state <= c_st_csum;
                            end
                        end
                    end
                    c_st_wait: begin
                        if (tx_done && (r_ret == c_st_payload)) begin
                            r_state <= c_st_payload;
                        end else if (tx_done && (r_ret == c_st_idle)) begin
                            r_done  <= 1'b1;
                            r_err   <= r_abort;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Scoreboard bench for uart_tx_sched with a simple UART model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    typedef struct {
        logic [7:0] b;
        bit         tight;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_grant_q[$];
    bit         exp_err_q[$];

    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    int  done_cyc = -100;
    int  nbytes = 0;
    int  nframes = 0;
    int  ngrants = 0;
    bit  outstanding = 1'b0;
    logic [3:0] prev_grant = '0;
    exp_t mon_e;
    logic [3:0] mon_g;
    bit   mon_err;

    uart_tx_sched #(
        .NUM_REQ        (4),
        .MAX_LEN        (4),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_b(input logic [7:0] b, input bit tight);
        exp_t e;
        e.b = b;
        e.tight = tight;
        exp_q.push_back(e);
    endtask

    task automatic push_hdr(input int id);
        exp_grant_q.push_back(4'(1 << id));
        push_b(8'hA5, 1'b0);
        push_b(8'(id), 1'b1);
    endtask

    task automatic push_end(input logic [7:0] csum, input bit tight, input bit err);
        push_b(csum, tight);
        exp_err_q.push_back(err);
    endtask

    // UART model: tx_done three cycles after each start pulse
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !reset) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: compares every UART byte, grant and frame completion
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 1'b0;
            prev_grant  = '0;
        end else begin
            if (tx_done) begin
                outstanding = 1'b0;
                done_cyc    = cyc;
            end
            if (tx_start) begin
                chk("tx_start_while_outstanding", 32'(outstanding), 32'd0);
                chk("busy_during_tx", 32'(busy), 32'd1);
                outstanding = 1'b1;
                nbytes++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_byte: actual=%0h required=none", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(mon_e.b));
                    if (mon_e.tight) chk("tx_gap_after_done", 32'(cyc - done_cyc), 32'd1);
                end
            end
            if (prev_grant == 4'd0 && grant != 4'd0) begin
                ngrants++;
                chk("grant_onehot", 32'($countones(grant)), 32'd1);
                if (exp_grant_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_grant: actual=%0h required=none", grant);
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    chk("grant_order", 32'(grant), 32'(mon_g));
                end
            end
            prev_grant = grant;
            if (frame_done) begin
                nframes++;
                if (exp_err_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame_done: actual=1 required=0");
                end else begin
                    mon_err = exp_err_q.pop_front();
                    chk("frame_err", 32'(frame_err), 32'(mon_err));
                end
            end else if (frame_err) begin
                chk("frame_err_without_done", 32'(frame_err), 32'd0);
            end
        end
    end

    task automatic wait_grant_drop(input int id);
        int n = 0;
        while (!grant[id] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("grant_wait", 32'(grant[id]), 32'd1);
        req[id] = 1'b0;
    endtask

    task automatic put_byte(input int id, input logic [7:0] b, input logic l);
        int n = 0;
        req_data[id*8 +: 8] = b;
        req_valid[id] = 1'b1;
        req_last[id]  = l;
        while (!req_ready[id] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready[id]), 32'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (nframes < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", 32'(nframes >= target), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: four clients, one-byte frames, pointer starts at 3
        base = nframes;
        push_hdr(0); push_b(8'h30, 1'b0); push_end(8'h30, 1'b1, 1'b0);
        push_hdr(1); push_b(8'h35, 1'b0); push_end(8'h34, 1'b1, 1'b0);
        push_hdr(2); push_b(8'h3A, 1'b0); push_end(8'h38, 1'b1, 1'b0);
        push_hdr(3); push_b(8'h3F, 1'b0); push_end(8'h3C, 1'b1, 1'b0);
        push_hdr(0); push_b(8'h30, 1'b0); push_end(8'h30, 1'b1, 1'b0);
        b0 = ngrants;
        req_data  = {8'h3F, 8'h3A, 8'h35, 8'h30};
        req_last  = 4'hF;
        req_valid = 4'hF;
        req       = 4'hF;
        for (int n = 0; n < 600 && ngrants < b0 + 5; n++) @(negedge clk);
        req = 4'h0;
        wait_frames(base + 5);
        req_valid = 4'h0;
        req_last  = 4'h0;
        repeat (3) @(negedge clk);

        // Single frame from client 1
        base = nframes;
        push_hdr(1); push_b(8'h11, 1'b0); push_b(8'h22, 1'b0); push_end(8'h32, 1'b1, 1'b0);
        req[1] = 1'b1;
        wait_grant_drop(1);
        put_byte(1, 8'h11, 1'b0);
        put_byte(1, 8'h22, 1'b1);
        wait_frames(base + 1);
        repeat (3) @(negedge clk);

        // Timeout: client 2 sends one byte then stalls
        base = nframes;
        push_hdr(2); push_b(8'h55, 1'b0); push_end(8'hA8, 1'b0, 1'b1);
        req[2] = 1'b1;
        wait_grant_drop(2);
        put_byte(2, 8'h55, 1'b0);
        wait_frames(base + 1);
        repeat (3) @(negedge clk);

        // Truncation: five bytes without last, cap is four
        base = nframes;
        push_hdr(0);
        push_b(8'h01, 1'b0); push_b(8'h02, 1'b0); push_b(8'h03, 1'b0); push_b(8'h04, 1'b0);
        push_end(8'hFB, 1'b1, 1'b1);
        push_hdr(0); push_b(8'h05, 1'b0); push_end(8'hFA, 1'b0, 1'b1);
        req[0] = 1'b1;
        put_byte(0, 8'h01, 1'b0);
        put_byte(0, 8'h02, 1'b0);
        put_byte(0, 8'h03, 1'b0);
        put_byte(0, 8'h04, 1'b0);
        put_byte(0, 8'h05, 1'b0);
        req[0] = 1'b0;
        wait_frames(base + 2);
        repeat (3) @(negedge clk);

        // Reset in the middle of a payload
        push_hdr(3); push_b(8'h77, 1'b0);
        b0 = nbytes;
        req[3] = 1'b1;
        wait_grant_drop(3);
        put_byte(3, 8'h77, 1'b0);
        for (int n = 0; n < 200 && nbytes < b0 + 3; n++) @(negedge clk);
        repeat (8) @(negedge clk);
        chk("pre_reset_ready", 32'(req_ready), 32'h8);
        #2 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Normal frame after reset
        base = nframes;
        push_hdr(3); push_b(8'h0F, 1'b0); push_end(8'h0C, 1'b1, 1'b0);
        req[3] = 1'b1;
        wait_grant_drop(3);
        put_byte(3, 8'h0F, 1'b1);
        wait_frames(base + 1);
        repeat (5) @(negedge clk);

        chk("bytes_left", 32'(exp_q.size()), 32'd0);
        chk("grants_left", 32'(exp_grant_q.size()), 32'd0);
        chk("frames_left", 32'(exp_err_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
